// File: rtl/vga_sync_generator.sv
// vga_sync_generator: free-running raster timing for 640x480 @ 60 Hz.
// Two compare-and-clear counters walk the raster; all outputs decode
// combinationally from them, so sync/visible flags line up with the coordinates.
module vga_sync_generator #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] screen_hpos,
  output logic [9:0] screen_vpos,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Decode boundaries pre-sized to the counter width to keep compares width-exact.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_S = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_E = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_S = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_E = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (screen_hpos == H_LAST);
  assign v_wrap = (screen_vpos == V_LAST);

  // Raster counters: column every clock, line on column wrap, both clear at their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_hpos <= '0;
      screen_vpos <= '0;
    end else if (h_wrap) begin
      screen_hpos <= '0;
      screen_vpos <= v_wrap ? '0 : screen_vpos + 10'd1;
    end else begin
      screen_hpos <= screen_hpos + 10'd1;
    end
  end

  // Zero-latency decode; hsync deliberately ignores vertical blanking.
  always_comb begin
    display_on = (screen_hpos < H_VIS) && (screen_vpos < V_VIS);
    hsync      = ((screen_hpos >= H_SYNC_S) && (screen_hpos <= H_SYNC_E)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync      = ((screen_vpos >= V_SYNC_S) && (screen_vpos <= V_SYNC_E)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_end  = h_wrap && v_wrap;
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: a full-size instance for horizontal timing and a
// shrunken-geometry instance (15x10 raster) so vertical/frame behaviour fits a short run.
module tb_vga_sync_generator;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fe;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n, rst_n_s;
  logic b_hs, b_vs, b_de, b_fe, s_hs, s_vs, s_de, s_fe;
  logic [9:0] b_h, b_v, s_h, s_v;
  obs_t obs_b, obs_s;

  obs_t qb[$];
  obs_t qs[$];
  int checks = 0;
  int failures = 0;
  int bh = 0, bv = 0, sh = 0, sv = 0;

  always #5 clk = ~clk;

  assign obs_b = {b_h, b_v, b_hs, b_vs, b_de, b_fe};
  assign obs_s = {s_h, s_v, s_hs, s_vs, s_de, s_fe};

  vga_sync_generator u_big (
    .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
    .screen_hpos(b_h), .screen_vpos(b_v), .frame_end(b_fe)
  );

  vga_sync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n_s), .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
    .screen_hpos(s_h), .screen_vpos(s_v), .frame_end(s_fe)
  );

  // Reference decode from explicit raster coordinates.
  function automatic obs_t dec(int h, int v, int hd, int hs0, int hs1, int ht,
                               int vd, int vs0, int vs1, int vt);
    obs_t o;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.de = (h < hd) && (v < vd);
    o.hs = !((h >= hs0) && (h <= hs1));
    o.vs = !((v >= vs0) && (v <= vs1));
    o.fe = (h == ht - 1) && (v == vt - 1);
    return o;
  endfunction

  function automatic obs_t exp_b();
    return dec(bh, bv, 640, 656, 751, 800, 480, 490, 491, 525);
  endfunction

  function automatic obs_t exp_s();
    return dec(sh, sv, 8, 10, 12, 15, 6, 7, 8, 10);
  endfunction

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  // One pixel clock: advance the models for whichever instance is running,
  // queue the expected outputs, and return at the sampling (falling) edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n)   adv(bh, bv, 800, 525);
    if (rst_n_s) adv(sh, sv, 15, 10);
    qb.push_back(exp_b());
    qs.push_back(exp_s());
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t rst_exp;
    rst_n = 1'b0;
    rst_n_s = 1'b0;
    rst_exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = qb.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL reset_sb_big got=%h exp=%h", obs_b, e); end
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL reset_sb_small got=%h exp=%h", obs_s, e); end
    end
    checks++;
    if (obs_b !== rst_exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs_b, rst_exp); end
    rst_n = 1'b1;
    rst_n_s = 1'b1;
    cycle();
    e = qb.pop_front();
    checks++;
    if (obs_b !== e) begin failures++; $display("FAIL release_sb_big got=%h exp=%h", obs_b, e); end
    e = qs.pop_front();
    checks++;
    if (obs_s !== e) begin failures++; $display("FAIL release_sb_small got=%h exp=%h", obs_s, e); end
    checks++;
    if (b_h !== 10'd1) begin failures++; $display("FAIL release_hpos got=%0d exp=1", b_h); end
  endtask

  task automatic test_line_timing();
    obs_t e;
    int hs_low = 0;
    int de_drop = -1;
    logic hs755 = 1'b0;
    for (int i = 0; i < 799; i++) begin
      cycle();
      e = qb.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL line_sb_big got=%h exp=%h", obs_b, e); end
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL line_sb_small got=%h exp=%h", obs_s, e); end
      if (b_v == 10'd0 && b_hs == 1'b0) hs_low++;
      if (b_v == 10'd0 && b_de == 1'b0 && de_drop < 0) de_drop = int'(b_h);
      if (b_h == 10'd755) hs755 = b_hs;
    end
    checks++;
    if (hs_low != 96) begin failures++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
    checks++;
    if (de_drop != 640) begin failures++; $display("FAIL display_drop got=%0d exp=640", de_drop); end
    checks++;
    if (hs755 !== 1'b1) begin failures++; $display("FAIL hsync_755 got=%0b exp=1", hs755); end
    checks++;
    if (b_h !== 10'd0 || b_v !== 10'd1) begin
      failures++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", b_h, b_v);
    end
  endtask

  task automatic test_vsync();
    obs_t e;
    int vs_low = 0;
    int de_blank = 0;
    for (int i = 0; i < 150; i++) begin
      cycle();
      e = qb.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL vsync_sb_big got=%h exp=%h", obs_b, e); end
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL vsync_sb_small got=%h exp=%h", obs_s, e); end
      if (s_vs == 1'b0) vs_low++;
      if (sv >= 6 && s_de == 1'b1) de_blank++;
    end
    checks++;
    if (vs_low != 30) begin failures++; $display("FAIL vsync_width got=%0d exp=30", vs_low); end
    checks++;
    if (de_blank != 0) begin failures++; $display("FAIL display_in_vblank got=%0d exp=0", de_blank); end
  endtask

  task automatic test_frame_end();
    obs_t e;
    int n_fe = 0;
    int first = -1, second = -1;
    int bad_next = 0;
    logic prev_fe = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      e = qb.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL frame_sb_big got=%h exp=%h", obs_b, e); end
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL frame_sb_small got=%h exp=%h", obs_s, e); end
      if (prev_fe && (s_h !== 10'd0 || s_v !== 10'd0 || s_fe !== 1'b0)) bad_next++;
      if (s_fe === 1'b1) begin
        n_fe++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      prev_fe = s_fe;
    end
    checks++;
    if (n_fe != 2) begin failures++; $display("FAIL frame_end_count got=%0d exp=2", n_fe); end
    checks++;
    if (second - first != 150) begin failures++; $display("FAIL frame_spacing got=%0d exp=150", second - first); end
    checks++;
    if (bad_next != 0) begin failures++; $display("FAIL frame_next_origin got=%0d exp=0", bad_next); end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int first_fe = -1;
    int guard = 0;
    // Small instance: abort mid-frame at (5,3).
    while (!(sh == 5 && sv == 3) && guard < 200) begin
      cycle();
      void'(qb.pop_front());
      void'(qs.pop_front());
      guard++;
    end
    checks++;
    if (guard >= 200) begin failures++; $display("FAIL mid_reset_reach_small got=%0d exp=<200", guard); end
    #2 rst_n_s = 1'b0;
    sh = 0; sv = 0;
    #1;
    checks++;
    if (s_h !== 10'd0 || s_v !== 10'd0) begin
      failures++; $display("FAIL async_reset_small got=(%0d,%0d) exp=(0,0)", s_h, s_v);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      void'(qb.pop_front());
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL held_reset_small got=%h exp=%h", obs_s, e); end
    end
    rst_n_s = 1'b1;
    for (int i = 1; i <= 160; i++) begin
      cycle();
      void'(qb.pop_front());
      e = qs.pop_front();
      checks++;
      if (obs_s !== e) begin failures++; $display("FAIL restart_sb_small got=%h exp=%h", obs_s, e); end
      if (s_fe === 1'b1 && first_fe < 0) first_fe = i;
    end
    checks++;
    if (first_fe != 149) begin failures++; $display("FAIL restart_first_frame_end got=%0d exp=149", first_fe); end
    // Full-size instance: abort at column 300.
    guard = 0;
    while (bh != 300 && guard < 900) begin
      cycle();
      void'(qb.pop_front());
      void'(qs.pop_front());
      guard++;
    end
    #2 rst_n = 1'b0;
    bh = 0; bv = 0;
    #1;
    checks++;
    if (b_h !== 10'd0 || b_v !== 10'd0 || b_de !== 1'b1 || b_hs !== 1'b1 || b_fe !== 1'b0) begin
      failures++; $display("FAIL async_reset_big got=%h exp=(0,0) idle", obs_b);
    end
    cycle();
    void'(qs.pop_front());
    e = qb.pop_front();
    checks++;
    if (obs_b !== e) begin failures++; $display("FAIL held_reset_big got=%h exp=%h", obs_b, e); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      void'(qs.pop_front());
      e = qb.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL restart_sb_big got=%h exp=%h", obs_b, e); end
    end
    checks++;
    if (b_h !== 10'd10 || b_v !== 10'd0) begin
      failures++; $display("FAIL restart_big_pos got=(%0d,%0d) exp=(10,0)", b_h, b_v);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_vsync();
    test_frame_end();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
